// File: rtl/ntt_arbiter.sv
// Shares one NTT core among NUM_REQ requesters: grant, 256-coefficient load, wait for completion, drain 256 results.
// Fixed-priority selection by default; define NTT_ARB_RR_EN for round-robin selection.
module ntt_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [NUM_REQ-1:0]     i_req_intt,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [16*NUM_REQ-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]     o_req_take,
  output logic [NUM_REQ-1:0]     o_gnt,
  output logic                   o_core_ready,
  output logic                   o_core_intt,
  output logic [15:0]            o_core_data,
  input  logic                   i_core_valid,
  input  logic [4095:0]          i_core_data,
  output logic                   o_res_valid,
  output logic [15:0]            o_res_data,
  output logic [1:0]             o_res_tag,
  output logic                   o_res_last,
  input  logic                   i_res_ready,
  output logic                   o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               intt_q, intt_d;
  logic [1:0]         idx_q, idx_d;

  logic               sel_any;
  logic [1:0]         sel_idx;
  logic               sel_intt;
  logic               g_vld;
  logic [15:0]        g_data;
  logic [15:0]        res_coef;

  assign sel_any = |i_req;

`ifdef NTT_ARB_RR_EN
  logic [1:0]           ptr_q, ptr_d;
  logic [2*NUM_REQ-1:0] req_rot;
  logic [2:0]           cand;

  // Rotate the request vector so bit 0 is the search start; the lowest set bit wins.
  always_comb begin
    req_rot = {i_req, i_req} >> ptr_q;
    sel_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        cand    = 3'(ptr_q) + 3'(k);
        sel_idx = (cand >= 3'(NUM_REQ)) ? 2'(cand - 3'(NUM_REQ)) : 2'(cand);
      end
    end
  end

  assign ptr_d = (sel_idx == 2'(NUM_REQ - 1)) ? 2'd0 : sel_idx + 2'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else if (state_q == S_IDLE && sel_any) begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) sel_idx = 2'(k);
    end
  end
`endif

  always_comb begin
    g_vld    = 1'b0;
    g_data   = '0;
    sel_intt = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (idx_q == 2'(k)) begin
        g_vld  = i_req_valid[k];
        g_data = i_req_data[16*k +: 16];
      end
      if (sel_idx == 2'(k)) sel_intt = i_req_intt[k];
    end
  end

  // Coefficient n lives at bits [16n+15:16n]; the counter doubles as the drain index.
  assign res_coef = i_core_data[{cnt_q, 4'b0000} +: 16];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      intt_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      intt_q  <= intt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    intt_d       = intt_q;
    idx_d        = idx_q;
    o_req_take   = '0;
    o_core_ready = 1'b0;
    o_core_data  = '0;
    o_res_valid  = 1'b0;
    o_res_data   = '0;
    o_res_tag    = '0;
    o_res_last   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (sel_any) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            gnt_d[k] = (sel_idx == 2'(k));
          end
          idx_d   = sel_idx;
          intt_d  = sel_intt;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        o_core_ready = g_vld;
        o_core_data  = g_data;
        o_req_take   = g_vld ? gnt_q : '0;
        if (g_vld) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd255) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_core_valid) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_res_valid = 1'b1;
        o_res_data  = res_coef;
        o_res_tag   = idx_q;
        o_res_last  = (cnt_q == 8'd255);
        if (i_res_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd255) begin
            gnt_d   = '0;
            intt_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_gnt       = gnt_q;
  assign o_core_intt = intt_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ntt_arbiter.sv
// Scoreboard bench for ntt_arbiter: sources feed per-requester coefficients, a core model transforms them, drained beats are checked.
module tb_ntt_arbiter;
  localparam int NR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_rst_n;
  logic [NR-1:0]     i_req, i_req_intt, i_req_valid;
  logic [16*NR-1:0]  i_req_data;
  logic [NR-1:0]     o_req_take, o_gnt;
  logic              o_core_ready, o_core_intt;
  logic [15:0]       o_core_data;
  logic              i_core_valid;
  logic [4095:0]     i_core_data;
  logic              o_res_valid, o_res_last, i_res_ready, o_busy;
  logic [15:0]       o_res_data;
  logic [1:0]        o_res_tag;

  ntt_arbiter #(.NUM_REQ(NR)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_req(i_req), .i_req_intt(i_req_intt), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
    .o_req_take(o_req_take), .o_gnt(o_gnt),
    .o_core_ready(o_core_ready), .o_core_intt(o_core_intt), .o_core_data(o_core_data),
    .i_core_valid(i_core_valid), .i_core_data(i_core_data),
    .o_res_valid(o_res_valid), .o_res_data(o_res_data), .o_res_tag(o_res_tag),
    .o_res_last(o_res_last), .i_res_ready(i_res_ready), .o_busy(o_busy)
  );

  logic [44:0] outs;
  assign outs = {o_gnt, o_req_take, o_core_ready, o_core_intt, o_core_data,
                 o_res_valid, o_res_last, o_res_tag, o_res_data, o_busy};

  typedef struct {
    logic [15:0] d;
    logic [1:0]  tag;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          gnt_log[$];
  int          stall_pts[$];
  int          vectors = 0, miscompares = 0;
  int          src_idx[NR];
  logic [15:0] core_mem[256];
  int          core_wait = 0, cyc = 0, gnt_cyc = 0, done_cnt = 0;
  int          tr_strobes = 0, tr_beats = 0, tr_drain_cyc = 0, tr_stalls = 0;
  int          last_drain_cyc = 0, last_stalls = 0, spur_at = -1;
  bit          core_fired = 0, real_pulse = 0, spur_done = 0, bp_mode = 0;
  bit          hold_pend = 0, post_last = 0;
  logic [15:0] hold_dat;
  logic [NR-1:0] prev_gnt = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] src_val(int k, int i);
    return 16'(k * 4096 + i);
  endfunction

  function automatic logic [15:0] core_f(logic [15:0] d);
    return 16'(32'(d) * 3 + 32'h1234);
  endfunction

  function automatic int oh_idx(logic [NR-1:0] v);
    int r = -1;
    for (int k = 0; k < NR; k++) if (v[k]) r = k;
    return r;
  endfunction

  // One clock: check outputs at the falling edge, then drive inputs just after the rising edge.
  task automatic step();
    int g;
    bit loading, exp_rdy;
    exp_t e;
    @(negedge clk);
    cyc++;
    g = oh_idx(o_gnt);
    if (post_last) begin
      chk("idle_after_last", {o_busy, o_gnt}, 0);
      post_last = 0;
    end
    if (o_gnt != 0 && prev_gnt == 0) begin
      chk("gnt_onehot", 64'($onehot(o_gnt)), 1);
      gnt_log.push_back(g);
      gnt_cyc = cyc;
    end
    chk("busy", o_busy, 64'(o_gnt != 0));
    loading = (g >= 0) && (tr_strobes < 256);
    exp_rdy = loading && i_req_valid[g];
    chk("core_rdy", o_core_ready, 64'(exp_rdy));
    chk("req_take", o_req_take, exp_rdy ? 64'(o_gnt) : 64'(0));
    if (g >= 0) chk("core_intt", o_core_intt, i_req_intt[g]);
    if (loading && !i_req_valid[g]) tr_stalls++;
    if (o_core_ready && g >= 0) begin
      chk("core_dat", o_core_data, src_val(g, src_idx[g]));
      core_mem[tr_strobes] = o_core_data;
      sb.push_back('{core_f(src_val(g, src_idx[g])), 2'(g), tr_strobes == 255});
      src_idx[g] = (src_idx[g] + 1) % 256;
      tr_strobes++;
      if (tr_strobes == 256) core_wait = 10;
    end
    chk("res_vld", o_res_valid, 64'(core_fired));
    if (o_res_valid) begin
      tr_drain_cyc++;
      if (hold_pend) chk("res_hold", o_res_data, hold_dat);
      hold_pend = 0;
      if (i_res_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("res_dat", o_res_data, e.d);
          chk("res_tag", o_res_tag, e.tag);
          chk("res_last", o_res_last, e.last);
        end
        tr_beats++;
        if (tr_beats == 256) begin
          done_cnt++;
          chk("strobes", tr_strobes, 256);
          last_drain_cyc = tr_drain_cyc;
          last_stalls = tr_stalls;
          tr_strobes = 0; tr_beats = 0; tr_drain_cyc = 0; tr_stalls = 0;
          core_fired = 0;
          post_last = 1;
        end
      end else begin
        hold_pend = 1;
        hold_dat = o_res_data;
      end
    end
    if (i_core_valid && real_pulse) core_fired = 1;
    prev_gnt = o_gnt;

    @(posedge clk);
    #1;
    i_core_valid = 0;
    real_pulse = 0;
    if (core_wait > 0) begin
      core_wait--;
      if (core_wait == 0) begin
        for (int n = 0; n < 256; n++) i_core_data[n*16 +: 16] = core_f(core_mem[n]);
        i_core_valid = 1;
        real_pulse = 1;
      end
    end else if (spur_at >= 0 && !spur_done && prev_gnt != 0 && tr_strobes == spur_at) begin
      i_core_valid = 1;
      spur_done = 1;
    end
    i_res_ready = bp_mode ? tr_drain_cyc[0] : 1'b1;
    for (int k = 0; k < NR; k++) begin
      i_req_valid[k] = 1'b1;
      i_req_data[k*16 +: 16] = src_val(k, src_idx[k]);
    end
    if (stall_pts.size() > 0 && prev_gnt != 0 && tr_strobes == stall_pts[0]) begin
      i_req_valid = '0;
      void'(stall_pts.pop_front());
    end
  endtask

  task automatic run(input int n_xfer, input int stop_load);
    int target = done_cnt + n_xfer;
    int g0 = gnt_log.size();
    int budget = 0;
    while (done_cnt < target) begin
      step();
      budget++;
      if (gnt_log.size() - g0 >= n_xfer) i_req = '0;
      if (stop_load >= 0 && tr_strobes == stop_load) break;
      if (budget > 4000 * n_xfer) begin
        chk("timeout", 64'(budget), 0);
        break;
      end
    end
  endtask

  initial begin
    int c0, g0;
    i_rst_n = 0; i_req = '1; i_req_intt = '1; i_req_valid = '1; i_req_data = '1;
    i_core_valid = 1; i_core_data = '0; i_res_ready = 1;
    for (int k = 0; k < NR; k++) src_idx[k] = 0;
    #2;
    chk("rst_outs", 64'(outs), 0);
    i_req = '0; i_req_intt = '0; i_core_valid = 0;
    repeat (3) @(posedge clk);
    #1 i_rst_n = 1;

    // Single request, continuous valid, data 0..255.
    i_req = 3'b001;
    c0 = cyc;
    run(1, -1);
    chk("gnt_latency", 64'(gnt_cyc - c0), 2);
    chk("single_gnt", 64'(gnt_log[gnt_log.size()-1]), 0);

    // Three stall cycles during load.
    stall_pts.push_back($urandom_range(10, 80));
    stall_pts.push_back($urandom_range(90, 160));
    stall_pts.push_back($urandom_range(170, 250));
    i_req = 3'b010;
    run(1, -1);
    chk("stall_cycles", 64'(last_stalls), 3);
    chk("stall_gnt", 64'(gnt_log[gnt_log.size()-1]), 1);

    // Drain backpressure: ready alternates 0/1.
    bp_mode = 1;
    i_req = 3'b100;
    run(1, -1);
    chk("drain_cycles", 64'(last_drain_cyc), 512);
    bp_mode = 0;

    // Contention held across three transforms.
    g0 = gnt_log.size();
    i_req = 3'b111;
    i_req_intt = 3'b101;
    run(3, -1);
`ifdef NTT_ARB_RR_EN
    chk("cont_gnt0", 64'(gnt_log[g0]), 0);
    chk("cont_gnt1", 64'(gnt_log[g0+1]), 1);
    chk("cont_gnt2", 64'(gnt_log[g0+2]), 2);
`else
    chk("cont_gnt0", 64'(gnt_log[g0]), 0);
    chk("cont_gnt1", 64'(gnt_log[g0+1]), 0);
    chk("cont_gnt2", 64'(gnt_log[g0+2]), 0);
`endif
    i_req_intt = '0;

    // Reset after 100 coefficients, then a fresh transform.
    i_req = 3'b001;
    run(1, 100);
    chk("pre_rst_strobes", 64'(tr_strobes), 100);
    i_rst_n = 0;
    #1;
    chk("rst_mid_outs", 64'(outs), 0);
    sb.delete();
    tr_strobes = 0; tr_beats = 0; tr_drain_cyc = 0; tr_stalls = 0;
    core_wait = 0; core_fired = 0; hold_pend = 0; post_last = 0; prev_gnt = '0;
    i_req = '0; i_core_valid = 0; real_pulse = 0;
    for (int k = 0; k < NR; k++) src_idx[k] = 0;
    @(posedge clk);
    #1 i_rst_n = 1;
    i_req = 3'b001;
    run(1, -1);
    chk("post_rst_gnt", 64'(gnt_log[gnt_log.size()-1]), 0);

    // Inverse transform with a spurious completion pulse during load.
    spur_at = 50;
    i_req = 3'b010;
    i_req_intt = 3'b010;
    run(1, -1);
    chk("spur_injected", 64'(spur_done), 1);
    chk("intt_gnt", 64'(gnt_log[gnt_log.size()-1]), 1);
    step();
    chk("sb_empty_end", 64'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ntt_arbiter.md
NTT_ARBITER -- requirements
Module: ntt_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, giving the number of requesters sharing one NTT core (range 2..4).
REQ-002 The block SHALL have port i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 The block SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port i_req  input  NUM_REQ  per-requester transform request, held high until granted.
REQ-005 The block SHALL have port i_req_intt  input  NUM_REQ  per-requester inverse flag, sampled at grant.
REQ-006 The block SHALL have port i_req_valid  input  NUM_REQ  per-requester coefficient-valid strobe.
REQ-007 The block SHALL have port i_req_data  input  16*NUM_REQ  per-requester signed coefficient; requester k uses bits [16k+15:16k].
REQ-008 The block SHALL have port o_req_take  output  NUM_REQ  asserted when the coefficient of the granted requester is consumed this cycle.
REQ-009 The block SHALL have port o_gnt  output  NUM_REQ  one-hot grant, held from grant through the last drained result.
REQ-010 The block SHALL have port o_core_ready  output  1  core load strobe; one coefficient per high cycle.
REQ-011 The block SHALL have port o_core_intt  output  1  core inverse flag.
REQ-012 The block SHALL have port o_core_data  output  16  core load coefficient.
REQ-013 The block SHALL have port i_core_valid  input  1  single-cycle core completion pulse.
REQ-014 The block SHALL have port i_core_data  input  4096  core result array; coefficient n (n = bank*32 + idx) at bits [16n+15:16n], stable after i_core_valid until the next load.
REQ-015 The block SHALL have port o_res_valid  output  1  result beat valid.
REQ-016 The block SHALL have port o_res_data  output  16  result coefficient.
REQ-017 The block SHALL have port o_res_tag  output  2  index of the owning requester.
REQ-018 The block SHALL have port o_res_last  output  1  marks coefficient 255.
REQ-019 The block SHALL have port i_res_ready  input  1  result sink ready.
REQ-020 The block SHALL have port o_busy  output  1  high in every state except S_IDLE.

Function
REQ-021 The FSM SHALL have states S_IDLE, S_LOAD, S_WAIT and S_DRAIN.
REQ-022 S_IDLE SHALL, when any i_req bit is high, select one requester, assert its o_gnt bit, latch its i_req_intt into o_core_intt, clear the 8-bit coefficient counter, and enter S_LOAD on the next edge; the grant is visible 1 cycle after the request.
REQ-023 With NTT_ARB_RR_EN undefined, requester selection SHALL be fixed priority, lowest index wins.
REQ-024 In S_LOAD, o_core_ready, o_req_take[g] and the counter increment SHALL all equal i_req_valid[g] of the granted requester g, with o_core_data = i_req_data[g] combinationally.
REQ-025 A low i_req_valid[g] in S_LOAD SHALL stall the load with o_core_ready low; stalls of any length are legal.
REQ-026 On the 256th accepted coefficient (counter wraps 255 -> 0), the FSM SHALL enter S_WAIT.
REQ-027 In S_WAIT, o_core_ready SHALL be 0, and i_core_valid SHALL move the FSM to S_DRAIN with the counter at 0.
REQ-028 In S_DRAIN, o_res_valid SHALL be 1, o_res_data SHALL equal coefficient[counter] of i_core_data, o_res_tag SHALL equal g, and o_res_last SHALL equal (counter == 255).
REQ-029 In S_DRAIN, the counter SHALL advance only on o_res_valid && i_res_ready; o_res_data SHALL hold stable while i_res_ready is low.
REQ-030 The accepted last beat SHALL clear o_gnt and return the FSM to S_IDLE; a new grant is possible on the following cycle.
REQ-031 i_req changes outside S_IDLE SHALL be ignored, and no grant SHALL change mid-transform.
REQ-032 i_core_valid outside S_WAIT SHALL be ignored.
REQ-033 i_req_valid of non-granted requesters SHALL never produce o_req_take.

Reset
REQ-034 Assertion of i_rst_n low SHALL immediately force S_IDLE, counter 0, o_gnt 0, o_req_take 0, o_core_ready 0, o_core_intt 0, o_core_data 0, o_res_valid 0, o_res_last 0, o_res_tag 0, o_res_data 0, o_busy 0, and round-robin pointer 0.
REQ-035 Reset mid-operation SHALL abandon the transform without emitting any result; the NTT core SHALL be reset from the same reset net so that its load count realigns.

Configuration
REQ-036 With macro NTT_ARB_RR_EN defined, selection SHALL be round-robin: the search starts at (last granted index + 1) mod NUM_REQ, and the pointer updates at each grant.
REQ-037 With NTT_ARB_RR_EN undefined, the pointer logic SHALL be absent and selection SHALL be fixed priority per REQ-023.

Verification
REQ-038 Scenario, single request: i_req=001, intt=0, continuous valid, data 0..255, core pulse 10 cycles after load, i_res_ready=1 -> grant after 1 cycle, exactly 256 core strobes, 256 beats tag 0, last on beat 255, then S_IDLE.
REQ-039 Scenario, load stall: i_req_valid low on 3 random cycles during load -> o_core_ready low on exactly those cycles, 256 strobes total.
REQ-040 Scenario, drain backpressure: i_res_ready toggles 1/0 during drain -> each coefficient emitted once, data held while not ready, 512 drain cycles.
REQ-041 Scenario, contention with RR undefined: i_req=111 held for three transforms -> grants 0,0,0; with NTT_ARB_RR_EN defined -> grants 0,1,2.
REQ-042 Scenario, mid-load reset: i_rst_n low after 100 coefficients -> all outputs 0 in the same cycle; a fresh request then completes normally.
REQ-043 Scenario, inverse and spurious completion: intt=1 request -> o_core_intt=1 throughout; an i_core_valid pulse injected during load is ignored.
